// File: rtl/seri_paket.sv
// rtl/seri_paket.sv - register offsets, DURUM bit positions and FSM states for seri_verici
package seri_paket;

  // Word offsets inside the 16-byte window, compared against (adres - base)[3:2].
  localparam logic [1:0] VERI_OFS  = 2'd0;
  localparam logic [1:0] DURUM_OFS = 2'd1;
  localparam logic [1:0] BOLEN_OFS = 2'd2;

  localparam int DOLU_BIT    = 0;
  localparam int BOS_BIT     = 1;
  localparam int MESGUL_BIT  = 2;
  localparam int TASMA_BIT   = 3;
  localparam int DOLULUK_LSB = 8;
  localparam int DOLULUK_MSB = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BASLA = 2'd1,
    VERI  = 2'd2,
    DUR   = 2'd3
  } durum_e;

endpackage

// File: rtl/seri_fifo.sv
// rtl/seri_fifo.sv - synchronous FIFO; a push while full is accepted only alongside a pop
module seri_fifo #(
  parameter int GENISLIK = 8,
  parameter int DERINLIK = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [GENISLIK-1:0]         veri_i,
  input  logic                        pop_i,
  output logic [GENISLIK-1:0]         veri_o,
  output logic                        dolu_o,
  output logic                        bos_o,
  output logic [$clog2(DERINLIK):0]   sayi_o
);

  localparam int AW = $clog2(DERINLIK);

  logic [GENISLIK-1:0] mem [DERINLIK];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         sayi_q;
  logic                push_ok, pop_ok;

  assign dolu_o  = (sayi_q == (AW+1)'(DERINLIK));
  assign bos_o   = (sayi_q == '0);
  assign sayi_o  = sayi_q;
  assign veri_o  = mem[rd_q];
  assign pop_ok  = pop_i && !bos_o;
  assign push_ok = push_i && (!dolu_o || pop_ok);

  // When full, the slot being written is the one being read out on the same edge.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= veri_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      sayi_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   sayi_q <= sayi_q + (AW+1)'(1);
        2'b01:   sayi_q <= sayi_q - (AW+1)'(1);
        default: sayi_q <= sayi_q;
      endcase
    end
  end

endmodule

// File: rtl/seri_verici.sv
// rtl/seri_verici.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the data-memory port
module seri_verici
  import seri_paket::*;
#(
  parameter logic [31:0] TABAN_ADRES      = 32'h2000_0000,
  parameter int          FIFO_DERINLIK    = 8,
  parameter logic [15:0] VARSAYILAN_BOLEN = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adres,
  input  logic [31:0] yaz_veri,
  input  logic        yaz_gecerli,
  output logic [31:0] oku_veri,
  output logic        sec_gecerli,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DERINLIK) + 1;

  logic [31:0] ofs;
  logic        yaz, veri_yaz, durum_yaz, bolen_yaz;
  logic        fifo_dolu, fifo_bos, pop, baslat, bit_sonu;
  logic [7:0]  fifo_veri;
  logic [CW-1:0] fifo_sayi;
  logic        unused_ust_bitler;

  durum_e      durum_q, durum_d;
  logic [15:0] bolen_q, bolen_d, div_q, div_d, sayac_q, sayac_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  kaydir_q, kaydir_d;
  logic        tx_q, tx_d, tasma_q, tasma_d;

  assign ofs         = adres - TABAN_ADRES;
  assign sec_gecerli = (ofs < 32'd16);
  assign yaz         = yaz_gecerli && sec_gecerli;
  assign veri_yaz    = yaz && (ofs[3:2] == VERI_OFS);
  assign durum_yaz   = yaz && (ofs[3:2] == DURUM_OFS);
  assign bolen_yaz   = yaz && (ofs[3:2] == BOLEN_OFS);
  assign unused_ust_bitler = ^yaz_veri[31:16];

  seri_fifo #(.GENISLIK(8), .DERINLIK(FIFO_DERINLIK)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (veri_yaz),
    .veri_i (yaz_veri[7:0]),
    .pop_i  (pop),
    .veri_o (fifo_veri),
    .dolu_o (fifo_dolu),
    .bos_o  (fifo_bos),
    .sayi_o (fifo_sayi)
  );

  // A same-edge DURUM clear and overflow cannot coincide: they need different offsets.
  assign tasma_d = (veri_yaz && fifo_dolu && !pop) ? 1'b1 :
                   (durum_yaz && yaz_veri[TASMA_BIT]) ? 1'b0 : tasma_q;
  assign bolen_d = bolen_yaz ? yaz_veri[15:0] : bolen_q;
  assign bit_sonu = (sayac_q == div_q - 16'd1);
  assign tx       = tx_q;

  always_comb begin
    durum_d  = durum_q;
    sayac_d  = sayac_q;
    bit_d    = bit_q;
    kaydir_d = kaydir_q;
    div_d    = div_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    baslat   = 1'b0;
    if (durum_q != IDLE) sayac_d = bit_sonu ? 16'd0 : sayac_q + 16'd1;
    case (durum_q)
      IDLE:  baslat = !fifo_bos;
      BASLA: if (bit_sonu) begin
        durum_d = VERI;
        bit_d   = 3'd0;
        tx_d    = kaydir_q[0];
      end
      VERI: if (bit_sonu) begin
        if (bit_q == 3'd7) begin
          durum_d = DUR;
          tx_d    = 1'b1;
        end else begin
          bit_d    = bit_q + 3'd1;
          kaydir_d = {1'b0, kaydir_q[7:1]};
          tx_d     = kaydir_q[1];
        end
      end
      DUR: if (bit_sonu) begin
        durum_d = IDLE;
        baslat  = !fifo_bos;
      end
      default: durum_d = IDLE;
    endcase
    // Starting straight out of the stop bit keeps back-to-back frames gapless.
    if (baslat) begin
      pop      = 1'b1;
      kaydir_d = fifo_veri;
      div_d    = (bolen_q == 16'd0) ? 16'd1 : bolen_q;
      sayac_d  = 16'd0;
      durum_d  = BASLA;
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q  <= IDLE;
      bolen_q  <= VARSAYILAN_BOLEN;
      div_q    <= 16'd1;
      sayac_q  <= 16'd0;
      bit_q    <= 3'd0;
      kaydir_q <= 8'd0;
      tx_q     <= 1'b1;
      tasma_q  <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      bolen_q  <= bolen_d;
      div_q    <= div_d;
      sayac_q  <= sayac_d;
      bit_q    <= bit_d;
      kaydir_q <= kaydir_d;
      tx_q     <= tx_d;
      tasma_q  <= tasma_d;
    end
  end

  always_comb begin
    oku_veri = 32'd0;
    if (sec_gecerli) begin
      case (ofs[3:2])
        DURUM_OFS: begin
          oku_veri[DOLU_BIT]                = fifo_dolu;
          oku_veri[BOS_BIT]                 = fifo_bos;
          oku_veri[MESGUL_BIT]              = (durum_q != IDLE);
          oku_veri[TASMA_BIT]               = tasma_q;
          oku_veri[DOLULUK_MSB:DOLULUK_LSB] = 5'(fifo_sayi);
        end
        BOLEN_OFS: oku_veri[15:0] = bolen_q;
        default:   oku_veri = 32'd0;
      endcase
    end
  end

endmodule
